mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline; sits between the EX/MEM pipeline register and the register-file write port.
//  Issues byte-lane-masked loads and stores to a variable-latency data memory over a req/ack handshake.
//  Aligns and extends load data, and stalls upstream while an access is outstanding.
//  Registers results into an internal MEM/WB register that drives writeback.
// PARAMETERS
//  WBCTRL_W   6   width of opaque writeback-control bundle (MemToReg/HiSrc/LoSrc/Link/RegDst), passed through untouched
// PORTS
//  Clk              in   1   clock; all state updates on rising edge
//  Rst              in   1   reset, synchronous, active-low
//  ex_valid         in   1   EX/MEM holds a live instruction
//  ex_alu_result    in   32  ALU result / effective address
//  ex_store_data    in   32  GPR[rt] for stores
//  ex_mem_read      in   1   load
//  ex_mem_write     in   1   store
//  ex_size          in   2   access size: 00 word, 01 half, 10 byte (11 illegal -> treated as word)
//  ex_load_unsigned in   1   1 = zero-extend (lbu/lhu), 0 = sign-extend
//  ex_dest          in   5   destination register
//  ex_wb_ctrl       in   WBCTRL_W  writeback control bundle
//  stall_o          out  1   upstream must hold EX/MEM contents
//  dmem_req         out  1   memory request
//  dmem_we          out  1   1 = write
//  dmem_addr        out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be          out  4   byte enables, little-endian
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_rdata       in   32  read data, valid with dmem_ack
//  dmem_ack         in   1   access complete (>=1 cycle after req)
//  wb_valid         out  1   MEM/WB holds a live instruction
//  wb_data          out  32  aligned/extended load data (loads) else ALU result
//  wb_dest          out  5   destination register
//  wb_wb_ctrl       out  WBCTRL_W  passed-through bundle
//  wb_misalign      out  1   misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (Rst=0 at edge): state=IDLE; every output 0 (wb_*, dmem_*, stall_o). A reset in ACCESS abandons the request; a late ack is ignored.
//  - FSM states: IDLE, ACCESS.
//    - IDLE, ex_valid & (read|write): latch addr/data/size/dest/ctrl into hold regs; goto ACCESS; MEM/WB loads wb_valid=0 (bubble).
//    - IDLE, ex_valid & no mem op: MEM/WB loads wb_data=ex_alu_result, wb_valid=1 (1-cycle latency).
//    - IDLE, !ex_valid: wb_valid<=0.
//    - ACCESS: dmem_req=1, other dmem_* driven from hold regs and stable until ack; wb_valid<=0 each cycle.
//    - ACCESS & dmem_ack: MEM/WB loads result (load: aligned rdata; store: alu result, wb_ctrl unchanged); wb_valid<=1; goto IDLE.
//  - stall_o = (state==ACCESS), registered-state only; no combinational path from ex_* or dmem_ack.
//  - Mem-op latency: from EX/MEM presentation to wb_valid = 1 + ack delay + 1 cycles.
//  - Read and write both set: write wins; rdata is discarded.
//  - Stores:
//    - word: be=1111
//    - half: be=0011 when addr[1]=0, else 1100; wdata={2{d[15:0]}}
//    - byte: be=0001<<addr[1:0]; wdata={4{d[7:0]}}
//  - Loads: select lane by addr[1:0] / addr[1], then sign- or zero-extend to 32 bits.
//  - wb_* hold their value whenever wb_valid is 0 except wb_valid itself.
// CONFIGURATION
//  - MEM_MISALIGN_TRAP_EN defined:
//    - Misaligned accesses (half & addr[0], word & addr[1:0]!=0) issue no dmem_req.
//    - They complete in 1 cycle as wb_valid=1, wb_misalign=1, wb_data=0.
//    - The writeback stage suppresses RegWrite when wb_misalign=1.
//  - MEM_MISALIGN_TRAP_EN undefined: low address bits ignored for the access size; wb_misalign tied 0.
// STRUCTURE
//  - Package mem_stage_pkg:
//    - size encodings SZ_WORD/SZ_HALF/SZ_BYTE
//    - state encoding ST_IDLE/ST_ACCESS
//    - default WBCTRL_W
//  - Sub-module mem_load_align: combinational lane select plus sign/zero extension. Inputs rdata, addr[1:0], size, unsigned; output 32b.
//  - Store lane/be generation stays inline.
// TESTING
//  - ALU op ex_alu_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234; stall_o never asserted.
//  - lb at 0x103, mem word 0x80FF_0000, ack after 3 cycles -> stall_o high 4 cycles, wb_data=0xFFFF_FF80.
//  - lhu at 0x102, rdata 0xBEEF_1234 -> wb_data=0x0000_BEEF.
//  - sb 0xAB at 0x201 -> dmem_addr=0x200, be=0010, wdata=0xABAB_ABAB, we=1, held stable until ack.
//  - Rst=0 while in ACCESS, ack arriving 1 cycle later -> IDLE, dmem_req=0, wb_valid stays 0.
//  - MEM_MISALIGN_TRAP_EN defined, lw at 0x102 -> no dmem_req, wb_valid=1, wb_misalign=1. Undefined -> dmem_addr=0x100, be=1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states,
// default writeback-control width and the alignment check.
package mem_stage_pkg;

  localparam int WBCTRL_W_DEFAULT = 6;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Illegal size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to the access size
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = rdata;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SZ_BYTE: data = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
      SZ_HALF: data = {{16{half_s[15] & ~is_unsigned}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues lane-masked loads/stores over a req/ack data-memory port,
// stalls upstream while outstanding, and registers results into MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into traps.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int WBCTRL_W = WBCTRL_W_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ex_valid,
  input  logic [31:0]         ex_alu_result,
  input  logic [31:0]         ex_store_data,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [1:0]          ex_size,
  input  logic                ex_load_unsigned,
  input  logic [4:0]          ex_dest,
  input  logic [WBCTRL_W-1:0] ex_wb_ctrl,
  output logic                stall_o,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ack,
  output logic                wb_valid,
  output logic [31:0]         wb_data,
  output logic [4:0]          wb_dest,
  output logic [WBCTRL_W-1:0] wb_wb_ctrl,
  output logic                wb_misalign
);

  state_e              state_r, state_nxt_s;
  logic                mem_op_s, misalign_s;
  logic [3:0]          be_s;
  logic [31:0]         wdata_s, load_data_s;
  logic [31:0]         hold_addr_r;
  logic [1:0]          hold_size_r;
  logic                hold_unsigned_r, hold_is_load_r;
  logic [4:0]          hold_dest_r;
  logic [WBCTRL_W-1:0] hold_ctrl_r;
  logic                dmem_we_r;
  logic [31:0]         dmem_addr_r, dmem_wdata_r;
  logic [3:0]          dmem_be_r;
  logic                wb_valid_r, wb_misalign_r;
  logic [31:0]         wb_data_r;
  logic [4:0]          wb_dest_r;
  logic [WBCTRL_W-1:0] wb_ctrl_r;

  assign mem_op_s = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = is_misaligned(ex_size, ex_alu_result[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Store lane replication and byte-enable generation for the incoming op
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = ex_store_data;
    case (ex_size)
      SZ_HALF: begin
        be_s    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{ex_store_data[15:0]}};
      end
      SZ_BYTE: begin
        be_s    = 4'b0001 << ex_alu_result[1:0];
        wdata_s = {4{ex_store_data[7:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = ex_store_data;
      end
    endcase
  end

  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (hold_addr_r[1:0]),
    .size        (hold_size_r),
    .is_unsigned (hold_unsigned_r),
    .data        (load_data_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold registers and memory-port registers; port fields stay stable until ack
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hold_addr_r     <= 32'h0000_0000;
      hold_size_r     <= 2'b00;
      hold_unsigned_r <= 1'b0;
      hold_is_load_r  <= 1'b0;
      hold_dest_r     <= 5'd0;
      hold_ctrl_r     <= '0;
      dmem_we_r       <= 1'b0;
      dmem_addr_r     <= 32'h0000_0000;
      dmem_be_r       <= 4'b0000;
      dmem_wdata_r    <= 32'h0000_0000;
    end else if (state_r == ST_IDLE && mem_op_s && !misalign_s) begin
      hold_addr_r     <= ex_alu_result;
      hold_size_r     <= ex_size;
      hold_unsigned_r <= ex_load_unsigned;
      hold_is_load_r  <= ex_mem_read & ~ex_mem_write;
      hold_dest_r     <= ex_dest;
      hold_ctrl_r     <= ex_wb_ctrl;
      dmem_we_r       <= ex_mem_write;
      dmem_addr_r     <= {ex_alu_result[31:2], 2'b00};
      dmem_be_r       <= be_s;
      dmem_wdata_r    <= wdata_s;
    end else if (state_r == ST_ACCESS && dmem_ack) begin
      dmem_we_r       <= 1'b0;
      dmem_addr_r     <= 32'h0000_0000;
      dmem_be_r       <= 4'b0000;
      dmem_wdata_r    <= 32'h0000_0000;
    end else begin
      dmem_we_r       <= dmem_we_r;
      dmem_addr_r     <= dmem_addr_r;
      dmem_be_r       <= dmem_be_r;
      dmem_wdata_r    <= dmem_wdata_r;
    end
  end

  // MEM/WB register; payload fields only change when a valid result is loaded
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wb_valid_r    <= 1'b0;
      wb_data_r     <= 32'h0000_0000;
      wb_dest_r     <= 5'd0;
      wb_ctrl_r     <= '0;
      wb_misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s && misalign_s) begin
            wb_valid_r    <= 1'b1;
            wb_data_r     <= 32'h0000_0000;
            wb_dest_r     <= ex_dest;
            wb_ctrl_r     <= ex_wb_ctrl;
            wb_misalign_r <= 1'b1;
          end else if (ex_valid && !mem_op_s) begin
            wb_valid_r    <= 1'b1;
            wb_data_r     <= ex_alu_result;
            wb_dest_r     <= ex_dest;
            wb_ctrl_r     <= ex_wb_ctrl;
            wb_misalign_r <= 1'b0;
          end else begin
            wb_valid_r    <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            wb_valid_r    <= 1'b1;
            wb_data_r     <= hold_is_load_r ? load_data_s : hold_addr_r;
            wb_dest_r     <= hold_dest_r;
            wb_ctrl_r     <= hold_ctrl_r;
            wb_misalign_r <= 1'b0;
          end else begin
            wb_valid_r    <= 1'b0;
          end
        end
        default: wb_valid_r <= 1'b0;
      endcase
    end
  end

  assign stall_o     = (state_r == ST_ACCESS);
  assign dmem_req    = (state_r == ST_ACCESS);
  assign dmem_we     = dmem_we_r;
  assign dmem_addr   = dmem_addr_r;
  assign dmem_be     = dmem_be_r;
  assign dmem_wdata  = dmem_wdata_r;
  assign wb_valid    = wb_valid_r;
  assign wb_data     = wb_data_r;
  assign wb_dest     = wb_dest_r;
  assign wb_wb_ctrl  = wb_ctrl_r;
  assign wb_misalign = wb_misalign_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// ALU/load/store traffic against an arithmetic reference model.
module tb_mem_access_stage;

  localparam int W = 6;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          ex_valid = 1'b0;
  logic [31:0]   ex_alu_result = 32'd0;
  logic [31:0]   ex_store_data = 32'd0;
  logic          ex_mem_read = 1'b0;
  logic          ex_mem_write = 1'b0;
  logic [1:0]    ex_size = 2'b00;
  logic          ex_load_unsigned = 1'b0;
  logic [4:0]    ex_dest = 5'd0;
  logic [W-1:0]  ex_wb_ctrl = '0;
  logic          stall_o, dmem_req, dmem_we;
  logic [31:0]   dmem_addr, dmem_wdata;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_rdata = 32'd0;
  logic          dmem_ack = 1'b0;
  logic          wb_valid, wb_misalign;
  logic [31:0]   wb_data;
  logic [4:0]    wb_dest;
  logic [W-1:0]  wb_wb_ctrl;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] exp_wb_data = 32'd0;

  mem_access_stage #(.WBCTRL_W(W)) dut (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_load_unsigned(ex_load_unsigned), .ex_dest(ex_dest),
    .ex_wb_ctrl(ex_wb_ctrl), .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_wb_ctrl(wb_wb_ctrl), .wb_misalign(wb_misalign)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: sizes in bytes, lanes by naturally aligned offset.
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b10) return 1;
    else if (sz == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] a);
    int n = nbytes(sz);
    int lane = int'(a) & ~(n - 1);
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    else if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    else return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    int n = nbytes(sz);
    int off;
    logic [31:0] v, mask;
    if (n == 4) return w;
    off  = (int'(a) & ~(n - 1)) * 8;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = (w >> off) & mask;
    if (!u && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit ref_trap(input logic [1:0] sz, input logic [1:0] a);
    return TRAP && ((int'(a) % nbytes(sz)) != 0);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] dest, input logic [W-1:0] ctrl);
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_alu_result = res; ex_dest = dest; ex_wb_ctrl = ctrl;
    step();
    ex_valid = 1'b0;
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_data", wb_data, res);
    chk("alu_dest", 32'(wb_dest), 32'(dest));
    chk("alu_ctrl", 32'(wb_wb_ctrl), 32'(ctrl));
    chk("alu_stall", 32'(stall_o), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    exp_wb_data = res;
  endtask

  task automatic do_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rword, input int delay,
                        input logic [4:0] dest, input logic [W-1:0] ctrl);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz;
    ex_load_unsigned = u; ex_alu_result = addr; ex_store_data = sdata;
    ex_dest = dest; ex_wb_ctrl = ctrl;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    if (ref_trap(sz, addr[1:0])) begin
      chk("trap_valid", 32'(wb_valid), 32'd1);
      chk("trap_flag", 32'(wb_misalign), 32'd1);
      chk("trap_data", wb_data, 32'd0);
      chk("trap_dest", 32'(wb_dest), 32'(dest));
      chk("trap_req", 32'(dmem_req), 32'd0);
      chk("trap_stall", 32'(stall_o), 32'd0);
      exp_wb_data = 32'd0;
      return;
    end
    for (int c = 0; c <= delay; c++) begin
      chk("acc_stall", 32'(stall_o), 32'd1);
      chk("acc_req", 32'(dmem_req), 32'd1);
      chk("acc_we", 32'(dmem_we), 32'(wr));
      chk("acc_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("acc_be", 32'(dmem_be), 32'(ref_be(sz, addr[1:0])));
      if (wr) chk("acc_wdata", dmem_wdata, ref_wdata(sz, sdata));
      chk("acc_wbvalid", 32'(wb_valid), 32'd0);
      chk("acc_wbhold", wb_data, exp_wb_data);
      if (c == delay) begin
        dmem_ack = 1'b1;
        dmem_rdata = rword;
      end
      step();
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
    end
    exp_wb_data = wr ? addr : ref_load(rword, addr[1:0], sz, u);
    chk("done_valid", 32'(wb_valid), 32'd1);
    chk("done_data", wb_data, exp_wb_data);
    chk("done_dest", 32'(wb_dest), 32'(dest));
    chk("done_ctrl", 32'(wb_wb_ctrl), 32'(ctrl));
    chk("done_misalign", 32'(wb_misalign), 32'd0);
    chk("done_stall", 32'(stall_o), 32'd0);
    chk("done_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wbvalid", 32'(wb_valid), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_wbdest", 32'(wb_dest), 32'd0);
    chk("rst_wbctrl", 32'(wb_wb_ctrl), 32'd0);
    chk("rst_misalign", 32'(wb_misalign), 32'd0);
    Rst = 1'b1;
    step();

    // Directed cases
    do_alu(32'h0000_1234, 5'd3, 6'h15);
    step();
    chk("bubble_valid", 32'(wb_valid), 32'd0);
    chk("bubble_hold", wb_data, exp_wb_data);
    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 3, 5'd4, 6'h01);
    do_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 32'hBEEF_1234, 1, 5'd5, 6'h02);
    do_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h1234_56AB, 32'd0, 2, 5'd6, 6'h03);
    do_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'd0, 32'hCAFE_F00D, 1, 5'd7, 6'h04);
    do_mem(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0046, 32'hA5A5_8001, 32'h1111_2222, 0, 5'd8, 6'h05);
    do_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'd0, 32'h0000_8001, 0, 5'd9, 6'h06);

    // Reset while an access is outstanding; the late ack must be ignored
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'b00;
    ex_alu_result = 32'h0000_0300; ex_dest = 5'd10;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("rstacc_stall", 32'(stall_o), 32'd1);
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0;
    chk("rstacc_stall2", 32'(stall_o), 32'd0);
    chk("rstacc_req", 32'(dmem_req), 32'd0);
    chk("rstacc_wbvalid", 32'(wb_valid), 32'd0);
    step();
    chk("rstacc_wbvalid2", 32'(wb_valid), 32'd0);
    chk("rstacc_wbdata", wb_data, 32'd0);
    exp_wb_data = 32'd0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        do_alu($urandom, 5'($urandom), 6'($urandom));
      end else begin
        do_mem((kind != 2) ? 1'b1 : 1'b0, (kind != 1) ? 1'b1 : 1'b0,
               2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), 5'($urandom), 6'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        step();
        chk("rnd_idle_valid", 32'(wb_valid), 32'd0);
        chk("rnd_idle_hold", wb_data, exp_wb_data);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
